// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream into instruction memory,
// XOR-checked, holding the processor in reset until a clean load.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   loaded
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   loaded_q, loaded_d;
    logic [ADDR_W:0]   loaded_inc;
    logic [7:0]        sum_q, sum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;

    logic xfer;
    logic len_bad;
    logic sum_ok;
    logic last_byte;

    assign xfer       = in_valid && in_ready;
    assign len_bad    = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_L);
    assign loaded_inc = loaded_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_byte  = (loaded_inc == len_q);
    assign sum_ok     = (in_data == sum_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
            S_LEN:  if (xfer) state_d = len_bad ? S_ERR : S_DATA;
            S_DATA: if (xfer && last_byte) state_d = S_CSUM;
            S_CSUM: if (xfer) state_d = sum_ok ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake ready depends only on the registered state.
    always_comb begin
        in_ready = (state_q == S_LEN) || (state_q == S_DATA)
                || (state_q == S_CSUM);
    end

    always_comb begin
        len_d    = len_q;
        loaded_d = loaded_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        err_d    = err_q;
        hold_d   = hold_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    loaded_d = '0;
                    sum_d    = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    hold_d   = 1'b1;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (len_bad) err_d = 1'b1;
                    else len_d = in_data[ADDR_W:0];
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_d     = 1'b1;
                    addr_d   = loaded_q[ADDR_W-1:0];
                    wdata_d  = in_data;
                    sum_d    = sum_q ^ in_data;
                    loaded_d = loaded_inc;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (sum_ok) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q    <= '0;
            loaded_q <= '0;
            sum_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            len_q    <= len_d;
            loaded_q <= loaded_d;
            sum_q    <= sum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign loaded    = loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized frames for prog_loader, checked against a
// frame-level model of expected writes, status and memory image.
module tb_prog_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   loaded;

    prog_loader #(.ADDR_W(AW), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .loaded(loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] dut_mem [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    int         wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         wr_cyc_q  [$];
    logic [7:0] pl [$];

    // Instruction-memory sink: each strobe is seen once mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            dut_mem[mem_addr] = mem_wdata;
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode);
        int gap;
        int n;
        gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_frame(input int len, input logic [7:0] csum,
                             input int mode, input bit inj);
        int s;
        int nw;
        int bad;
        bit legal;
        bit ok;
        logic [7:0] x;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulse_start();
        s = cyc;
        chk("start_ready", 32'(in_ready), 1);
        chk("start_done", 32'(done), 0);
        chk("start_err", 32'(err), 0);
        chk("start_hold", 32'(cpu_hold), 1);
        chk("start_loaded", 32'(loaded), 0);
        legal = (len >= 1) && (len <= DEPTH);
        x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        ok = legal && (csum == x);
        send_byte(8'(len), mode);
        if (legal) begin
            for (int i = 0; i < len; i++) begin
                if (inj && i == 1) pulse_start();
                send_byte(pl[i], mode);
            end
            send_byte(csum, mode);
        end
        chk("end_done", 32'(done), 32'(ok));
        chk("end_err", 32'(err), 32'(!ok));
        chk("end_hold", 32'(cpu_hold), 32'(!ok));
        chk("end_ready", 32'(in_ready), 0);
        chk("end_loaded", 32'(loaded), legal ? 32'(len) : 0);
        if (mode == 0 && !inj)
            chk("frame_time", 32'(cyc - s), legal ? 32'(len + 2) : 1);
        tick();
        if (legal)
            for (int i = 0; i < len; i++) exp_mem[i] = pl[i];
        nw = legal ? len : 0;
        chk("wr_count", 32'(wr_addr_q.size()), 32'(nw));
        for (int i = 0; i < wr_addr_q.size() && i < nw; i++) begin
            chk("wr_addr", 32'(wr_addr_q[i]), 32'(i));
            chk("wr_data", 32'(wr_data_q[i]), 32'(pl[i]));
            if (i > 0 && mode == 0 && !inj)
                chk("wr_b2b", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 1);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dut_mem[i] !== exp_mem[i]) bad++;
        chk("mem_image", 32'(bad), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len;
        int r;
        logic [7:0] x;
        logic [7:0] b0;
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end

        #12;
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_hold", 32'(cpu_hold), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_loaded", 32'(loaded), 0);
        tick();
        reset = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 0);
        in_valid = 1'b0;

        pl.delete();
        pl.push_back(8'h01); pl.push_back(8'h22);
        pl.push_back(8'h11); pl.push_back(8'h60);
        run_frame(4, 8'h52, 0, 1'b0);
        run_frame(4, 8'h53, 0, 1'b0);

        pl.delete();
        run_frame(0, 8'h00, 0, 1'b0);
        run_frame(17, 8'h00, 0, 1'b0);

        pl.delete();
        for (int i = 0; i < DEPTH; i++) pl.push_back(8'(i));
        run_frame(16, 8'h00, 1, 1'b0);

        pl.delete();
        pl.push_back(8'h01); pl.push_back(8'h22);
        pl.push_back(8'h11); pl.push_back(8'h60);
        run_frame(4, 8'h52, 0, 1'b1);

        pl.delete();
        pl.push_back(8'hA5);
        run_frame(1, 8'hA5, 0, 1'b0);

        wr_addr_q.delete();
        pulse_start();
        send_byte(8'h04, 0);
        b0 = 8'h3C;
        send_byte(b0, 0);
        send_byte(8'hC3, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_hold", 32'(cpu_hold), 1);
        chk("mid_rst_loaded", 32'(loaded), 0);
        chk("mid_rst_done", 32'(done), 0);
        exp_mem[0] = b0;
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_wr_count", 32'(wr_addr_q.size()), 1);
        chk("post_rst_ready", 32'(in_ready), 0);
        pl.delete();
        pl.push_back(8'h5A); pl.push_back(8'h0F);
        run_frame(2, 8'h55, 0, 1'b0);

        for (int f = 0; f < 24; f++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                len = ($urandom_range(0, 1) == 0) ? 0
                    : int'($urandom_range(17, 255));
            else
                len = int'($urandom_range(1, DEPTH));
            pl.delete();
            x = 8'h00;
            if (len >= 1 && len <= DEPTH)
                for (int i = 0; i < len; i++) begin
                    pl.push_back(8'($urandom));
                    x ^= pl[i];
                end
            if ($urandom_range(0, 3) == 0)
                x ^= 8'($urandom_range(1, 255));
            run_frame(len, x, int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader upstream of the 4-bit RISC processor. It accepts a framed byte stream over a valid/ready handshake and writes the payload into instruction memory through a dedicated write port, starting at address 0. It validates the frame with an XOR checksum and holds the processor in reset until a frame loads cleanly.

## Interface
Parameters:
- ADDR_W, 4, instruction-memory address width; DEPTH = 2**ADDR_W words
- DATA_W, 8, instruction word width; fixed at 8 for this processor

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new load from IDLE, DONE or ERR
- in_valid  in  1  in_data carries a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- cpu_hold  out  1  active-high reset request to the processor
- done  out  1  last frame loaded and verified
- err  out  1  last frame rejected
- loaded  out  ADDR_W+1  payload bytes written in the current/last frame

## Operation
- Frame format: LEN byte (1..DEPTH), then LEN payload bytes, then a CSUM byte equal to the XOR of all payload bytes.
- A byte transfers when in_valid && in_ready are both high on a rising clk edge.
- States:
  - IDLE: in_ready=0. start -> LEN; clears loaded, the running XOR and the address.
  - LEN: in_ready=1. On transfer, LEN==0 or LEN>DEPTH -> ERR; otherwise latch LEN and go to DATA.
  - DATA: in_ready=1. On each transfer, write the byte to the current address and XOR it into the running checksum. Address and loaded increment. After the LEN-th byte -> CSUM.
  - CSUM: in_ready=1. On transfer, byte equal to the running XOR -> DONE; otherwise -> ERR.
  - DONE: in_ready=0, done=1, cpu_hold=0. start -> LEN, and cpu_hold returns to 1.
  - ERR: in_ready=0, err=1, cpu_hold=1. start -> LEN.
- start is ignored in LEN, DATA and CSUM.
- The address never wraps. LEN≤DEPTH bounds writes to 0..DEPTH-1.
- Payload already written before an ERR stays in memory. Only cpu_hold gates its use.
- mem_addr and mem_wdata hold their last value when mem_we=0.

## Timing
- Reset values:
  - state IDLE
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_hold=1, done=0, err=0, loaded=0
- in_ready is decoded from the registered state only. It has no combinational path from in_valid.
- Memory writes are registered. A payload byte accepted at edge N produces mem_we=1 with its address and data during cycle N+1, for exactly one cycle. Back-to-back accepts produce back-to-back writes.
- done, err and cpu_hold update on the edge that accepts the CSUM byte, or the LEN byte for an illegal length.
- A start pulse at edge N puts the loader in LEN from cycle N+1. done, err and loaded clear, and cpu_hold rises, on that same edge.
- in_valid gaps are allowed anywhere. State is held until the next transfer.
- Asserting reset at any point, including mid-frame, immediately forces all reset values. An in-flight mem_we is dropped, and the loader waits in IDLE for start.
- Throughput: one byte per cycle. Total frame time with no stalls is LEN+2 cycles after start.

## Test plan
- Basic load: start, then 04, 01, 22, 11, 60, 52 back-to-back -> writes mem[0..3] = 01, 22, 11, 60, one per cycle; done=1, cpu_hold=0, loaded=4, err=0.
- Bad checksum: same frame with CSUM 53 -> all four writes occur; err=1, done=0, cpu_hold=1.
- Illegal length: start, then LEN 00 -> err=1, no mem_we. Repeat with LEN 11 (17) at ADDR_W=4 -> err=1, no mem_we.
- Full depth with stalls: LEN 10 (16), payload 00..0F with in_valid low on every other cycle, CSUM 00 -> 16 writes to addresses 0..15, no address wrap, done=1, loaded=16.
- Reset mid-frame: assert reset after the 2nd payload byte -> next cycle mem_we=0, in_ready=0, cpu_hold=1, loaded=0. After release and a new start, a valid frame loads correctly.
- Reload: after DONE, pulse start -> cpu_hold=1, done=0 next cycle. Load a 1-byte frame (01, A5, A5) -> mem[0]=A5, done=1.
